// File: rtl/round_enum_pkg.sv
// round_enum_pkg
// Shared definitions for the sequential single-precision divider:
//   round_values  - rounding-mode encoding captured alongside the operands
//   STATUS_*      - bit positions inside the 8-bit status word
//   CANONICAL_NAN - quiet NaN returned for every invalid division
package round_enum_pkg;

   typedef enum logic [2:0] {
      IEEE_near = 3'd0,
      IEEE_zero = 3'd1,
      IEEE_pinf = 3'd2,
      IEEE_ninf = 3'd3,
      near_up   = 3'd4,
      away_zero = 3'd5
   } round_values;

   localparam int STATUS_ZERO    = 0;
   localparam int STATUS_INF     = 1;
   localparam int STATUS_NAN     = 2;
   localparam int STATUS_TINY    = 3;
   localparam int STATUS_HUGE    = 4;
   localparam int STATUS_INEXACT = 5;
   localparam int STATUS_DIV0    = 6;

   localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp_div_round.sv
// fp_div_round
// Combinational back end of the divider: normalises the raw quotient by at
// most one left shift, rounds it in the selected mode and resolves overflow
// and underflow into the packed IEEE-754 result and its status flags.
// Ports:
//   sign_i       - result sign
//   exp_i        - biased exponent before normalisation (10-bit signed)
//   quot_i       - ITER quotient bits, MSB is the integer bit
//   remNonZero_i - final partial remainder is non-zero
//   round_i      - rounding mode
//   z_o          - packed single-precision result
//   status_o     - status flags (zero/inf/tiny/huge/inexact)
module fp_div_round
   import round_enum_pkg::*;
#(
   parameter int ITER = 26
) (
   input  logic              sign_i,
   input  logic signed [9:0] exp_i,
   input  logic [ITER-1:0]   quot_i,
   input  logic              remNonZero_i,
   input  round_values       round_i,
   output logic [31:0]       z_o,
   output logic [7:0]        status_o
);

   logic [ITER-2:0]   quotNorm;
   logic signed [9:0] expNorm;
   logic [22:0]       frac;
   logic              guardBit;
   logic              stickyBit;
   logic              inexact;
   logic              roundUp;
   logic [23:0]       fracRounded;
   logic signed [9:0] expRounded;
   logic              overflowToInf;
   logic              underflowToMin;

   // Quotient lies in (0.5, 2): when the integer bit is clear, one left shift
   // brings the leading one into place. The hidden bit is dropped here; what
   // remains is 23 fraction bits, the guard bit and the leftover low bits.
   always_comb begin
      if (quot_i[ITER-1]) begin
         quotNorm = quot_i[ITER-2:0];
         expNorm  = exp_i;
      end else begin
         quotNorm = {quot_i[ITER-3:0], 1'b0};
         expNorm  = exp_i - 10'sd1;
      end
      frac      = quotNorm[ITER-2:ITER-24];
      guardBit  = quotNorm[ITER-25];
      stickyBit = (|quotNorm[ITER-26:0]) | remNonZero_i;
      inexact   = guardBit | stickyBit;
   end

   // Rounding increment per mode; near_up breaks ties away from zero.
   always_comb begin
      roundUp = 1'b0;
      case (round_i)
         IEEE_near: roundUp = guardBit & (stickyBit | frac[0]);
         IEEE_zero: roundUp = 1'b0;
         IEEE_pinf: roundUp = inexact & ~sign_i;
         IEEE_ninf: roundUp = inexact & sign_i;
         near_up:   roundUp = guardBit;
         away_zero: roundUp = inexact;
         default:   roundUp = 1'b0;
      endcase
      // A carry out of the fraction leaves it all zero and bumps the exponent.
      fracRounded = {1'b0, frac} + {23'd0, roundUp};
      expRounded  = expNorm + $signed({9'd0, fracRounded[23]});
   end

   // Overflow saturates to infinity unless the mode rounds toward zero for
   // this sign; underflow flushes to zero unless the mode rounds away from
   // zero for this sign, in which case the smallest normal is returned.
   always_comb begin
      overflowToInf  = (round_i == IEEE_near) || (round_i == near_up) ||
                       (round_i == away_zero) ||
                       ((round_i == IEEE_pinf) && !sign_i) ||
                       ((round_i == IEEE_ninf) && sign_i);
      underflowToMin = (round_i == away_zero) ||
                       ((round_i == IEEE_pinf) && !sign_i) ||
                       ((round_i == IEEE_ninf) && sign_i);
      status_o = 8'd0;
      if (expRounded > 10'sd254) begin
         status_o[STATUS_HUGE]    = 1'b1;
         status_o[STATUS_INEXACT] = 1'b1;
         if (overflowToInf) begin
            z_o                  = {sign_i, 8'hFF, 23'd0};
            status_o[STATUS_INF] = 1'b1;
         end else begin
            z_o = {sign_i, 8'hFE, {23{1'b1}}};
         end
      end else if (expRounded < 10'sd1) begin
         status_o[STATUS_TINY]    = 1'b1;
         status_o[STATUS_INEXACT] = 1'b1;
         if (underflowToMin) begin
            z_o = {sign_i, 8'h01, 23'd0};
         end else begin
            z_o                   = {sign_i, 31'd0};
            status_o[STATUS_ZERO] = 1'b1;
         end
      end else begin
         z_o                      = {sign_i, expRounded[7:0], fracRounded[22:0]};
         status_o[STATUS_INEXACT] = inexact;
      end
   end

endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq
// Sequential IEEE-754 single-precision divider: one restoring radix-2
// quotient bit per cycle, followed by a combinational rounding stage.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   a, b, round         - dividend, divisor, rounding mode (captured on accept)
//   in_valid / in_ready - operand handshake (ready only while idle)
//   z, status           - quotient and flags, held until the next result
//   out_valid/out_ready - result handshake
// Build option: FP_DIV_BYPASS_EN - special operands skip DIVIDE/ROUND and
// jump straight from UNPACK to DONE.
module fp_div_seq
   import round_enum_pkg::*;
#(
   parameter int ITER = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  round_values round,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] z,
   output logic [7:0]  status,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int CW = $clog2(ITER + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] UNPACK = 3'd1;
   localparam logic [2:0] DIVIDE = 3'd2;
   localparam logic [2:0] ROUND  = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [31:0]       aReg_q, bReg_q;
   round_values       roundReg_q;
   logic              sign_q;
   logic signed [9:0] exp_q;
   logic [24:0]       rem_q;
   logic [23:0]       divisor_q;
   logic [ITER-1:0]   quot_q;
   logic [CW-1:0]     count_q;
   logic              special_q;
   logic [31:0]       specialZ_q;
   logic [7:0]        specialStatus_q;
   logic [31:0]       z_q;
   logic [7:0]        status_q;

   logic [7:0]        expA, expB;
   logic [22:0]       manA, manB;
   logic              aZero, bZero, aInf, bInf, aNan, bNan;
   logic              resSign;
   logic signed [9:0] expDiff;
   logic              specialHit;
   logic [31:0]       specialZ;
   logic [7:0]        specialStatus;
   logic [25:0]       remDiff;
   logic              quotBit;
   logic [24:0]       remNext;
   logic [31:0]       roundZ;
   logic [7:0]        roundStatus;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign z         = z_q;
   assign status    = status_q;

   // Field split of the captured operands; denormals count as zero.
   always_comb begin
      expA    = aReg_q[30:23];
      expB    = bReg_q[30:23];
      manA    = aReg_q[22:0];
      manB    = bReg_q[22:0];
      aZero   = (expA == 8'd0);
      bZero   = (expB == 8'd0);
      aInf    = (expA == 8'hFF) && (manA == 23'd0);
      bInf    = (expB == 8'hFF) && (manB == 23'd0);
      aNan    = (expA == 8'hFF) && (manA != 23'd0);
      bNan    = (expB == 8'hFF) && (manB != 23'd0);
      resSign = aReg_q[31] ^ bReg_q[31];
      expDiff = $signed({2'b00, expA}) - $signed({2'b00, expB}) + 10'sd127;
   end

   // Special-operand results in priority order. inf/0 lands in the inf/finite
   // branch because zero is finite, so it raises inf without div_by_zero.
   always_comb begin
      specialHit    = 1'b1;
      specialZ      = 32'd0;
      specialStatus = 8'd0;
      if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) begin
         specialZ                   = CANONICAL_NAN;
         specialStatus[STATUS_NAN]  = 1'b1;
      end else if (aInf) begin
         specialZ                   = {resSign, 8'hFF, 23'd0};
         specialStatus[STATUS_INF]  = 1'b1;
      end else if (bZero) begin
         specialZ                   = {resSign, 8'hFF, 23'd0};
         specialStatus[STATUS_INF]  = 1'b1;
         specialStatus[STATUS_DIV0] = 1'b1;
      end else if (aZero || bInf) begin
         specialZ                   = {resSign, 31'd0};
         specialStatus[STATUS_ZERO] = 1'b1;
      end else begin
         specialHit                 = 1'b0;
      end
   end

   // One restoring step: subtract when the partial remainder covers the
   // divisor, then shift the remainder left for the next quotient bit.
   always_comb begin
      remDiff = {1'b0, rem_q} - {2'b00, divisor_q};
      quotBit = ~remDiff[25];
      remNext = (quotBit ? remDiff[24:0] : rem_q) << 1;
   end

   fp_div_round #(
      .ITER(ITER)
   ) roundUnit (
      .sign_i      (sign_q),
      .exp_i       (exp_q),
      .quot_i      (quot_q),
      .remNonZero_i(|rem_q),
      .round_i     (roundReg_q),
      .z_o         (roundZ),
      .status_o    (roundStatus)
   );

   // Next-state selection; DIVIDE leaves after its last counted step.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (in_valid) state_d = UNPACK;
`ifdef FP_DIV_BYPASS_EN
         UNPACK: state_d = specialHit ? DONE : DIVIDE;
`else
         UNPACK: state_d = DIVIDE;
`endif
         DIVIDE: if (count_q == CW'(1)) state_d = ROUND;
         ROUND:  state_d = DONE;
         DONE:   if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers; z/status only change when a new result is produced.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         aReg_q          <= 32'd0;
         bReg_q          <= 32'd0;
         roundReg_q      <= IEEE_near;
         sign_q          <= 1'b0;
         exp_q           <= 10'sd0;
         rem_q           <= 25'd0;
         divisor_q       <= 24'd0;
         quot_q          <= '0;
         count_q         <= '0;
         special_q       <= 1'b0;
         specialZ_q      <= 32'd0;
         specialStatus_q <= 8'd0;
         z_q             <= 32'd0;
         status_q        <= 8'd0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  aReg_q     <= a;
                  bReg_q     <= b;
                  roundReg_q <= round;
               end
            end
            UNPACK: begin
               sign_q          <= resSign;
               exp_q           <= expDiff;
               rem_q           <= {2'b01, manA};
               divisor_q       <= {1'b1, manB};
               quot_q          <= '0;
               count_q         <= CW'(ITER);
               special_q       <= specialHit;
               specialZ_q      <= specialZ;
               specialStatus_q <= specialStatus;
`ifdef FP_DIV_BYPASS_EN
               if (specialHit) begin
                  z_q      <= specialZ;
                  status_q <= specialStatus;
               end
`endif
            end
            DIVIDE: begin
               rem_q   <= remNext;
               quot_q  <= {quot_q[ITER-2:0], quotBit};
               count_q <= count_q - CW'(1);
            end
            ROUND: begin
               z_q      <= special_q ? specialZ_q : roundZ;
               status_q <= special_q ? specialStatus_q : roundStatus;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 The block SHALL expose these ports, in this order:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- a  in  32  IEEE-754 single dividend.
- b  in  32  IEEE-754 single divisor.
- round  in  round_values  rounding mode, captured with operands.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- z  out  32  quotient a / b.
- status  out  8  flags: [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [5] inexact, [6] div_by_zero, [7] reserved 0.
- out_valid  out  1  z/status valid.
- out_ready  in  1  consumer accepts result.
REQ-002 Parameter ITER, default 26, SHALL set the quotient bits produced: 24 significand, 1 guard, 1 round; remainder forms sticky.

Function
REQ-003 FSM states SHALL be IDLE, UNPACK, DIVIDE, ROUND, DONE.
REQ-004 in_ready SHALL be 1 only in IDLE; accept = in_valid && in_ready; a, b and round register on accept; FSM goes to UNPACK.
REQ-005 UNPACK SHALL split fields, flush denormal inputs to signed zero, compute sign = a[31]^b[31], exponent = ea - eb + 127 in 10-bit signed arithmetic, and load the significands with hidden bit.
REQ-006 DIVIDE SHALL run one restoring radix-2 step per cycle for exactly ITER cycles under a down-counter; sticky = OR of the final remainder.
REQ-007 ROUND SHALL normalise by at most one left shift (decrementing the exponent) and apply round per mode: IEEE_near (ties-to-even), IEEE_zero, IEEE_pinf, IEEE_ninf, near_up, away_zero; mantissa carry-out SHALL increment the exponent.
REQ-008 Exponent > 254 after rounding SHALL set huge+inexact; z = infinity for near/away/sign-matching directed modes, else max normal 0x7F7FFFFF with sign.
REQ-009 Exponent < 1 SHALL set tiny+inexact; z = signed zero, or min normal 0x00800000 with sign when the mode rounds away from zero in that sign's direction.
REQ-010 Special cases (result exponent ignored): NaN operand or 0/0 or inf/inf -> 0x7FC00000, nan; x/0 (x finite nonzero) -> signed inf, inf+div_by_zero; inf/finite -> signed inf, inf; 0/nonzero or finite/inf -> signed zero, zero.
REQ-011 Exact results SHALL leave inexact 0; zero/inf flags SHALL also set for rounded results that equal zero/inf.
REQ-012 Latency: out_valid SHALL rise ITER+3 clock edges after the accepting edge (29 by default).
REQ-013 In DONE, out_valid = 1 and z/status SHALL hold stable until out_valid && out_ready; that edge returns to IDLE and z/status keep their values while out_valid = 0.
REQ-014 in_valid outside IDLE SHALL be ignored; operand changes during DIVIDE SHALL not affect the result.
REQ-015 Throughput: a new accept SHALL occur no earlier than the cycle after a DONE handshake.

Reset
REQ-016 rst high SHALL asynchronously force IDLE, counter 0, z = 0, status = 0, out_valid = 0, in_ready = 1 on release, and captured round = IEEE_near.
REQ-017 Reset mid-DIVIDE or in DONE SHALL discard the operation with no result emitted.

Configuration
REQ-018 Macro FP_DIV_BYPASS_EN defined: special cases of REQ-010 SHALL go UNPACK -> DONE, with out_valid 2 edges after accept. Undefined: they SHALL traverse DIVIDE/ROUND with the same REQ-010 outputs and REQ-012 latency.

Structure
REQ-019 round_values SHALL remain in round_enum_pkg; status bit index constants and the canonical NaN 0x7FC00000 SHALL be added there; the FSM state enum SHALL be local.
REQ-020 Rounding, overflow and underflow logic SHALL be one combinational sub-module fp_div_round; the iteration datapath SHALL stay in fp_div_seq.

Verification
REQ-021 0x40C00000 / 0x40000000, IEEE_near -> z = 0x40400000, status 0x00, out_valid at edge 29.
REQ-022 0x3F800000 / 0x40400000: IEEE_near -> 0x3EAAAAAB; IEEE_zero -> 0x3EAAAAAA; status 0x20 in both.
REQ-023 0x3F800000 / 0x00000000 -> 0x7F800000, status 0x42; 0x00000000 / 0x00000000 -> 0x7FC00000, status 0x04.
REQ-024 0x7F000000 / 0x00800000: IEEE_near -> 0x7F800000, status 0x32; IEEE_zero -> 0x7F7FFFFF, status 0x30.
REQ-025 Hold out_ready = 0 for 10 cycles after out_valid -> z/status/out_valid stable and in_ready = 0; release -> IDLE the next edge.
REQ-026 Assert rst at DIVIDE cycle 10 -> outputs 0 immediately, no out_valid; the next operation completes correctly. Also, with FP_DIV_BYPASS_EN defined, REQ-023 completes in 2 edges.
